dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
Load/store unit sitting directly downstream of the core's memory stage, between the core data-memory port and a wait-stated data bus.
- Converts byte/half/word accesses into word-aligned bus transactions with byte enables.
- Extracts and sign- or zero-extends load data.
- Stalls the pipeline until the bus completes, with misalignment detection and a bus timeout.

Parameters:
TIMEOUT_CYCLES, 255, cycles spent in REQ+WAIT_R before aborting with bus_err_o; range 1..255.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid_i  in  1  core requests a memory access this cycle
req_write_i  in  1  1 = store, 0 = load
req_addr_i  in  32  byte address
req_wdata_i  in  32  store data, right-aligned
req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned_i  in  1  load zero-extends when 1
stall_o  out  1  core must hold its memory stage
rdata_o  out  32  extended load data
rdata_valid_o  out  1  one-cycle pulse: access done (load or store)
misaligned_o  out  1  request rejected as misaligned or illegal
bus_err_o  out  1  one-cycle pulse: access aborted by timeout
BUS_req_o  out  1  bus request
BUS_we_o  out  1  bus write enable
BUS_addr_o  out  32  word address, [1:0] = 00
BUS_be_o  out  4  byte enables
BUS_wdata_o  out  32  lane-replicated store data
BUS_gnt_i  in  1  bus accepted request this cycle
BUS_rvalid_i  in  1  read data valid
BUS_rdata_i  in  32  read data

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous and active-low.
- Reset values: state IDLE; every registered output 0, including BUS_* outputs, rdata_o, rdata_valid_o and bus_err_o; timeout counter 0.
- States: IDLE, REQ, WAIT_R, DONE.
- Misaligned condition (combinational):
  - half with addr[0]=1
  - word with addr[1:0]≠00
  - size 11
- misaligned_o = IDLE & req_valid_i & misaligned. No bus activity and no stall result.
- Accept condition: IDLE & req_valid_i & !misaligned.
  - Capture write, addr[1:0], size, unsigned.
  - Register BUS_addr_o = {addr[31:2],2'b00}, BUS_be_o, BUS_wdata_o and BUS_we_o.
  - Next state REQ.
- REQ:
  - BUS_req_o = 1; BUS_* outputs held stable.
  - On gnt: BUS_req_o drops next cycle; store goes to DONE, load goes to WAIT_R.
- WAIT_R: on rvalid, register rdata_o = extend(rdata >> 8*offset); go to DONE.
- DONE: rdata_valid_o = 1 for exactly this cycle, then IDLE. A new request is not accepted in DONE.
- stall_o (combinational) = accept | REQ | WAIT_R. stall_o is 0 in DONE, so the core advances while rdata_o is valid.
- Minimum latency (T = accept cycle):
  - store: gnt at T+1, DONE at T+2
  - load: gnt at T+1, rvalid at T+2, DONE at T+3
  - rvalid arriving in REQ is ignored.
- Byte enables and write-data replication:
  - byte: be = 0001<<addr[1:0], wdata = {4{wdata[7:0]}}
  - half: be = 0011<<addr[1:0], wdata = {2{wdata[15:0]}}
  - word: be = 1111, wdata passed through
- Load extension: byte and half are sign-extended unless unsigned; word is passed through.
- Timeout:
  - Counter clears on accept and increments each cycle in REQ or WAIT_R.
  - When the count equals TIMEOUT_CYCLES while still waiting: go to DONE, drive bus_err_o = 1 in DONE, rdata_o = 0, BUS_req_o = 0.
  - If gnt or rvalid arrives in the same cycle as the timeout, the bus response wins.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. An outstanding bus response arriving afterwards is ignored.

Decomposition:
- Package lsu_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - state encoding
  - default TIMEOUT width (8 bits)
- Sub-module lsu_align (purely combinational) computes be, replicated wdata, misaligned flag and extended load data. The top holds the FSM, capture registers and counter.

Test Plan:
- SB to 0x1003, wdata 0x000000AB, gnt at T+1 -> BUS_addr 0x1000, be 1000, wdata 0xABABABAB, stall high T..T+1, rdata_valid at T+2.
- LH at 0x2002, BUS_rdata 0x8001_1234 -> rdata_o 0xFFFF8001; repeat with LHU -> 0x00008001.
- LW to 0x0005 -> misaligned_o=1 same cycle, stall_o=0, no BUS_req_o; size 11 behaves identically.
- LW at 0x0100, gnt delayed 3 cycles, rvalid 2 more cycles later -> stall held throughout, rdata_o = BUS_rdata, one-cycle rdata_valid, next request accepted the cycle after DONE.
- TIMEOUT_CYCLES=4, gnt never asserted -> bus_err_o pulse at cycle T+5, rdata_o=0, BUS_req_o low, FSM back to IDLE.
- reset_n low while in WAIT_R -> all outputs 0 asynchronously; a late rvalid after reset release produces no rdata_valid_o.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and bus payload type for the data-memory load/store unit.
package lsu_pkg;

    localparam int unsigned TIMEOUT_W = 8;
    localparam int unsigned CNT_W     = TIMEOUT_W + 1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_R,
        ST_DONE
    } lsu_state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication, alignment check, load extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  req_size_i,
    input  logic [1:0]  req_off_i,
    input  logic [31:0] req_wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o,
    input  logic [1:0]  ld_size_i,
    input  logic [1:0]  ld_off_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] ld_shifted;

    always_comb begin
        be_o         = 4'b1111;
        wdata_o      = req_wdata_i;
        misaligned_o = 1'b0;
        case (req_size_i)
            SZ_BYTE: begin
                be_o    = 4'(4'b0001 << req_off_i);
                wdata_o = {4{req_wdata_i[7:0]}};
            end
            SZ_HALF: begin
                be_o         = 4'(4'b0011 << req_off_i);
                wdata_o      = {2{req_wdata_i[15:0]}};
                misaligned_o = req_off_i[0];
            end
            SZ_WORD: begin
                misaligned_o = (req_off_i != 2'b00);
            end
            default: begin
                misaligned_o = 1'b1;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend to 32 bits.
    always_comb begin
        ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};
        ld_data_o  = ld_shifted;
        case (ld_size_i)
            SZ_BYTE: ld_data_o = ld_unsigned_i ? {24'h0, ld_shifted[7:0]}
                                               : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            SZ_HALF: ld_data_o = ld_unsigned_i ? {16'h0, ld_shifted[15:0]}
                                               : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            default: ld_data_o = ld_shifted;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: turns core byte/half/word accesses into word-aligned, wait-stated bus
// transactions, stalling the core until completion or timeout.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid_i,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        misaligned_o,
    output logic        bus_err_o,
    output logic        BUS_req_o,
    output logic        BUS_we_o,
    output logic [31:0] BUS_addr_o,
    output logic [3:0]  BUS_be_o,
    output logic [31:0] BUS_wdata_o,
    input  logic        BUS_gnt_i,
    input  logic        BUS_rvalid_i,
    input  logic [31:0] BUS_rdata_i
);

    lsu_state_e            state_q, state_d;
    bus_req_t              bus_q, bus_d;
    logic                  bus_req_q, bus_req_d;
    logic [1:0]            off_q, off_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  rdata_valid_q, rdata_valid_d;
    logic                  bus_err_q, bus_err_d;

    logic [3:0]            be_c;
    logic [31:0]           wdata_rep_c;
    logic                  misaligned_c;
    logic [31:0]           ld_data_c;
    logic                  accept_c;
    logic [CNT_W-1:0]      cnt_inc_c;
    logic                  timeout_c;

    lsu_align u_align (
        .req_size_i    (req_size_i),
        .req_off_i     (req_addr_i[1:0]),
        .req_wdata_i   (req_wdata_i),
        .be_o          (be_c),
        .wdata_o       (wdata_rep_c),
        .misaligned_o  (misaligned_c),
        .ld_size_i     (size_q),
        .ld_off_i      (off_q),
        .ld_unsigned_i (uns_q),
        .ld_rdata_i    (BUS_rdata_i),
        .ld_data_o     (ld_data_c)
    );

    assign accept_c     = (state_q == ST_IDLE) && req_valid_i && !misaligned_c;
    assign misaligned_o = (state_q == ST_IDLE) && req_valid_i && misaligned_c;
    assign stall_o      = accept_c || (state_q == ST_REQ) || (state_q == ST_WAIT_R);

    // Count includes the current waiting cycle, so the abort lands after exactly TIMEOUT_CYCLES.
    assign cnt_inc_c = CNT_W'(cnt_q) + CNT_W'(1);
    assign timeout_c = (cnt_inc_c == CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        state_d       = state_q;
        bus_d         = bus_q;
        bus_req_d     = bus_req_q;
        off_d         = off_q;
        size_d        = size_q;
        uns_d         = uns_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        bus_err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    off_d     = req_addr_i[1:0];
                    size_d    = req_size_i;
                    uns_d     = req_unsigned_i;
                    bus_d     = '{we:    req_write_i,
                                  addr:  {req_addr_i[31:2], 2'b00},
                                  be:    be_c,
                                  wdata: wdata_rep_c};
                    bus_req_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_d = TIMEOUT_W'(cnt_inc_c);
                // A grant in the timeout cycle still completes the access.
                if (BUS_gnt_i) begin
                    bus_req_d = 1'b0;
                    if (bus_q.we) begin
                        rdata_valid_d = 1'b1;
                        state_d       = ST_DONE;
                    end else begin
                        state_d = ST_WAIT_R;
                    end
                end else if (timeout_c) begin
                    bus_req_d = 1'b0;
                    rdata_d   = '0;
                    bus_err_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_WAIT_R: begin
                cnt_d = TIMEOUT_W'(cnt_inc_c);
                if (BUS_rvalid_i) begin
                    rdata_d       = ld_data_c;
                    rdata_valid_d = 1'b1;
                    state_d       = ST_DONE;
                end else if (timeout_c) begin
                    rdata_d   = '0;
                    bus_err_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            bus_q         <= '0;
            bus_req_q     <= 1'b0;
            off_q         <= '0;
            size_q        <= '0;
            uns_q         <= 1'b0;
            cnt_q         <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bus_q         <= bus_d;
            bus_req_q     <= bus_req_d;
            off_q         <= off_d;
            size_q        <= size_d;
            uns_q         <= uns_d;
            cnt_q         <= cnt_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            bus_err_q     <= bus_err_d;
        end
    end

    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    assign bus_err_o     = bus_err_q;
    assign BUS_req_o     = bus_req_q;
    assign BUS_we_o      = bus_q.we;
    assign BUS_addr_o    = bus_q.addr;
    assign BUS_be_o      = bus_q.be;
    assign BUS_wdata_o   = bus_q.wdata;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: vector table for single accesses plus stall, timeout and reset sequences.
module tb_dmem_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_valid_to = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = SZ_WORD;
    logic        req_unsigned = 1'b0;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        gnt_to = 1'b0;
    logic        rvalid_to = 1'b0;

    logic        stall_o, rdata_valid_o, misaligned_o, bus_err_o, BUS_req_o, BUS_we_o;
    logic [31:0] rdata_o, BUS_addr_o, BUS_wdata_o;
    logic [3:0]  BUS_be_o;

    logic        stall_to, rdata_valid_to, misaligned_to, bus_err_to, BUS_req_to, BUS_we_to;
    logic [31:0] rdata_to, BUS_addr_to, BUS_wdata_to;
    logic [3:0]  BUS_be_to;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_lsu dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid_i(req_valid), .req_write_i(req_write), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
        .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
        .misaligned_o(misaligned_o), .bus_err_o(bus_err_o),
        .BUS_req_o(BUS_req_o), .BUS_we_o(BUS_we_o), .BUS_addr_o(BUS_addr_o),
        .BUS_be_o(BUS_be_o), .BUS_wdata_o(BUS_wdata_o),
        .BUS_gnt_i(bus_gnt), .BUS_rvalid_i(bus_rvalid), .BUS_rdata_i(bus_rdata)
    );

    // Second instance with a short timeout and a bus that never responds.
    dmem_lsu #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .reset_n(reset_n),
        .req_valid_i(req_valid_to), .req_write_i(req_write), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
        .stall_o(stall_to), .rdata_o(rdata_to), .rdata_valid_o(rdata_valid_to),
        .misaligned_o(misaligned_to), .bus_err_o(bus_err_to),
        .BUS_req_o(BUS_req_to), .BUS_we_o(BUS_we_to), .BUS_addr_o(BUS_addr_to),
        .BUS_be_o(BUS_be_to), .BUS_wdata_o(BUS_wdata_to),
        .BUS_gnt_i(gnt_to), .BUS_rvalid_i(rvalid_to), .BUS_rdata_i(bus_rdata)
    );

    typedef struct {
        string       name;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] brdata;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] ewdata;
        logic [31:0] erdata;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input string name, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                                input logic [31:0] brdata, input logic mis, input logic [3:0] be,
                                input logic [31:0] ewdata, input logic [31:0] erdata);
        vec_t v;
        v.name = name; v.wr = wr; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns;
        v.brdata = brdata; v.mis = mis; v.be = be; v.ewdata = ewdata; v.erdata = erdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] eaddr;
        eaddr        = {v.addr[31:2], 2'b00};
        req_valid    = 1'b1;
        req_write    = v.wr;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_size     = v.size;
        req_unsigned = v.uns;
        #1;
        chkb({v.name, ".misaligned"}, misaligned_o, v.mis);
        chkb({v.name, ".stall_T"}, stall_o, !v.mis);
        tick();
        req_valid = 1'b0;
        #1;
        if (v.mis) begin
            chkb({v.name, ".no_bus_req"}, BUS_req_o, 1'b0);
            chkb({v.name, ".no_stall"}, stall_o, 1'b0);
            return;
        end
        chkb({v.name, ".bus_req"}, BUS_req_o, 1'b1);
        chkb({v.name, ".bus_we"}, BUS_we_o, v.wr);
        chk({v.name, ".bus_addr"}, BUS_addr_o, eaddr);
        chk({v.name, ".bus_be"}, 32'(BUS_be_o), 32'(v.be));
        if (v.wr) chk({v.name, ".bus_wdata"}, BUS_wdata_o, v.ewdata);
        chkb({v.name, ".stall_T1"}, stall_o, 1'b1);
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        if (v.wr) begin
            #1;
            chkb({v.name, ".st_done_valid"}, rdata_valid_o, 1'b1);
            chkb({v.name, ".st_done_stall"}, stall_o, 1'b0);
            chkb({v.name, ".st_req_drop"}, BUS_req_o, 1'b0);
        end else begin
            bus_rvalid = 1'b1;
            bus_rdata  = v.brdata;
            #1;
            chkb({v.name, ".req_drop"}, BUS_req_o, 1'b0);
            chkb({v.name, ".wait_stall"}, stall_o, 1'b1);
            chkb({v.name, ".wait_novalid"}, rdata_valid_o, 1'b0);
            tick();
            bus_rvalid = 1'b0;
            bus_rdata  = 32'h5A5A5A5A;
            #1;
            chkb({v.name, ".ld_done_valid"}, rdata_valid_o, 1'b1);
            chk({v.name, ".rdata"}, rdata_o, v.erdata);
            chkb({v.name, ".ld_done_stall"}, stall_o, 1'b0);
        end
        tick();
        chkb({v.name, ".valid_pulse_end"}, rdata_valid_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vq.push_back(mk("sb_1003",   1'b1, 32'h1003, 32'h000000AB, SZ_BYTE, 1'b0, 32'h0,        1'b0, 4'b1000, 32'hABABABAB, 32'h0));
        vq.push_back(mk("lh_2002",   1'b0, 32'h2002, 32'h0,        SZ_HALF, 1'b0, 32'h80011234, 1'b0, 4'b1100, 32'h0,        32'hFFFF8001));
        vq.push_back(mk("lhu_2002",  1'b0, 32'h2002, 32'h0,        SZ_HALF, 1'b1, 32'h80011234, 1'b0, 4'b1100, 32'h0,        32'h00008001));
        vq.push_back(mk("lw_0005",   1'b0, 32'h0005, 32'h0,        SZ_WORD, 1'b0, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0));
        vq.push_back(mk("sz11_0100", 1'b0, 32'h0100, 32'h0,        2'b11,   1'b0, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0));
        vq.push_back(mk("lb_0001",   1'b0, 32'h0001, 32'h0,        SZ_BYTE, 1'b0, 32'h0000F000, 1'b0, 4'b0010, 32'h0,        32'hFFFFFFF0));
        vq.push_back(mk("lbu_0003",  1'b0, 32'h0003, 32'h0,        SZ_BYTE, 1'b1, 32'h9A000000, 1'b0, 4'b1000, 32'h0,        32'h0000009A));
        vq.push_back(mk("sh_0042",   1'b1, 32'h0042, 32'h1234BEEF, SZ_HALF, 1'b0, 32'h0,        1'b0, 4'b1100, 32'hBEEFBEEF, 32'h0));
        vq.push_back(mk("sw_0080",   1'b1, 32'h0080, 32'hDEADBEEF, SZ_WORD, 1'b0, 32'h0,        1'b0, 4'b1111, 32'hDEADBEEF, 32'h0));
        vq.push_back(mk("lw_0010",   1'b0, 32'h0010, 32'h0,        SZ_WORD, 1'b0, 32'hCAFEF00D, 1'b0, 4'b1111, 32'h0,        32'hCAFEF00D));
        vq.push_back(mk("lh_0003",   1'b0, 32'h0003, 32'h0,        SZ_HALF, 1'b0, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0));
        vq.push_back(mk("lb_0002",   1'b0, 32'h0002, 32'h0,        SZ_BYTE, 1'b0, 32'h00450000, 1'b0, 4'b0100, 32'h0,        32'h00000045));
        vq.push_back(mk("sb_0000",   1'b1, 32'h0000, 32'hFFFFFF12, SZ_BYTE, 1'b0, 32'h0,        1'b0, 4'b0001, 32'h12121212, 32'h0));
        vq.push_back(mk("lwu_0020",  1'b0, 32'h0020, 32'h0,        SZ_WORD, 1'b1, 32'h80000000, 1'b0, 4'b1111, 32'h0,        32'h80000000));

        // Reset state
        #1;
        chkb("rst.stall", stall_o, 1'b0);
        chk("rst.rdata", rdata_o, 32'h0);
        chkb("rst.rdata_valid", rdata_valid_o, 1'b0);
        chkb("rst.bus_err", bus_err_o, 1'b0);
        chkb("rst.bus_req", BUS_req_o, 1'b0);
        chkb("rst.bus_we", BUS_we_o, 1'b0);
        chk("rst.bus_addr", BUS_addr_o, 32'h0);
        chk("rst.bus_be", 32'(BUS_be_o), 32'h0);
        chk("rst.bus_wdata", BUS_wdata_o, 32'h0);
        #21;
        reset_n = 1'b1;
        tick();

        foreach (vq[i]) run_vec(vq[i]);

        // Delayed grant and read data; rvalid during REQ must be ignored
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0100; req_size = SZ_WORD; req_unsigned = 1'b0;
        #1;
        chkb("dly.stall_T", stall_o, 1'b1);
        tick();
        req_valid = 1'b0;
        #1;
        chkb("dly.bus_req_T1", BUS_req_o, 1'b1);
        chk("dly.bus_addr", BUS_addr_o, 32'h0100);
        tick();
        bus_rvalid = 1'b1; bus_rdata = 32'hBAD0BAD0;
        #1;
        chkb("dly.stall_T2", stall_o, 1'b1);
        tick();
        bus_rvalid = 1'b0;
        #1;
        chkb("dly.stall_T3", stall_o, 1'b1);
        chkb("dly.bus_req_T3", BUS_req_o, 1'b1);
        chkb("dly.no_valid_T3", rdata_valid_o, 1'b0);
        tick();
        bus_gnt = 1'b1;
        #1;
        chkb("dly.stall_T4", stall_o, 1'b1);
        tick();
        bus_gnt = 1'b0;
        #1;
        chkb("dly.req_drop_T5", BUS_req_o, 1'b0);
        chkb("dly.stall_T5", stall_o, 1'b1);
        tick();
        bus_rvalid = 1'b1; bus_rdata = 32'h13579BDF;
        #1;
        chkb("dly.stall_T6", stall_o, 1'b1);
        chkb("dly.no_valid_T6", rdata_valid_o, 1'b0);
        tick();
        bus_rvalid = 1'b0;
        #1;
        chkb("dly.done_valid", rdata_valid_o, 1'b1);
        chk("dly.rdata", rdata_o, 32'h13579BDF);
        chkb("dly.done_stall", stall_o, 1'b0);
        // Request presented in DONE is not taken; it is taken the following cycle
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0104; req_wdata = 32'h11223344; req_size = SZ_WORD;
        #1;
        chkb("dly.no_accept_done", stall_o, 1'b0);
        tick();
        chkb("dly.valid_one_cycle", rdata_valid_o, 1'b0);
        chkb("dly.accept_after_done", stall_o, 1'b1);
        tick();
        req_valid = 1'b0;
        #1;
        chkb("nxt.bus_req", BUS_req_o, 1'b1);
        chk("nxt.bus_addr", BUS_addr_o, 32'h0104);
        chkb("nxt.bus_we", BUS_we_o, 1'b1);
        chk("nxt.bus_wdata", BUS_wdata_o, 32'h11223344);
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        #1;
        chkb("nxt.done_valid", rdata_valid_o, 1'b1);
        tick();

        // Timeout on the short-timeout instance: gnt never arrives
        begin
            int n;
            req_valid_to = 1'b1; req_write = 1'b0; req_addr = 32'h0200; req_size = SZ_WORD;
            tick();
            req_valid_to = 1'b0;
            #1;
            chkb("to.bus_req_T1", BUS_req_to, 1'b1);
            n = 1;
            while (bus_err_to !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            chk("to.err_cycle", 32'(n), 32'd5);
            chkb("to.bus_err", bus_err_to, 1'b1);
            chk("to.rdata", rdata_to, 32'h0);
            chkb("to.bus_req_low", BUS_req_to, 1'b0);
            chkb("to.stall_low", stall_to, 1'b0);
            tick();
            chkb("to.err_pulse_end", bus_err_to, 1'b0);
            req_valid_to = 1'b1; req_size = 2'b11;
            #1;
            chkb("to.back_idle", misaligned_to, 1'b1);
            req_valid_to = 1'b0; req_size = SZ_WORD;
            tick();
        end

        // Reset while waiting for read data; late rvalid must be ignored
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0300; req_size = SZ_WORD;
        tick();
        req_valid = 1'b0;
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        #1;
        chk("rstw.pre_addr", BUS_addr_o, 32'h0300);
        chkb("rstw.pre_stall", stall_o, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chkb("rstw.stall", stall_o, 1'b0);
        chk("rstw.rdata", rdata_o, 32'h0);
        chkb("rstw.bus_req", BUS_req_o, 1'b0);
        chk("rstw.bus_addr", BUS_addr_o, 32'h0);
        chk("rstw.bus_be", 32'(BUS_be_o), 32'h0);
        chkb("rstw.rdata_valid", rdata_valid_o, 1'b0);
        #2;
        reset_n = 1'b1;
        tick();
        bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
        tick();
        bus_rvalid = 1'b0;
        #1;
        chkb("rstw.late_no_valid", rdata_valid_o, 1'b0);
        chkb("rstw.late_no_stall", stall_o, 1'b0);
        chk("rstw.late_rdata", rdata_o, 32'h0);
        tick();
        chkb("rstw.late_no_valid2", rdata_valid_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
